// File: rtl/instr_fetch_ifid_if.sv
// Instruction-fetch bundle: fetch control, instruction-memory bus and IF/ID outputs.
// The slave modport is the fetch stage. The master modport is its environment:
// the hazard/branch unit, instruction memory and decoder.
//   stall_i, branch_taken_i, branch_target_i : fetch control into the stage
//   imem_addr_o / imem_data_i                : combinational-read instruction memory
//   pc_o, instr_o, instr_op_o, pc_plus4_o    : fetch PC and IF/ID register contents
//   valid_o, halted_o                        : IF/ID occupancy and halt status
interface instr_fetch_ifid_if #(
   parameter int unsigned PC_WIDTH = 32
);
   logic                stall_i;
   logic                branch_taken_i;
   logic [PC_WIDTH-1:0] branch_target_i;
   logic [PC_WIDTH-1:0] imem_addr_o;
   logic [31:0]         imem_data_i;
   logic [PC_WIDTH-1:0] pc_o;
   logic [31:0]         instr_o;
   logic [5:0]          instr_op_o;
   logic [PC_WIDTH-1:0] pc_plus4_o;
   logic                valid_o;
   logic                halted_o;

   modport slave (
      input  stall_i, branch_taken_i, branch_target_i, imem_data_i,
      output imem_addr_o, pc_o, instr_o, instr_op_o, pc_plus4_o, valid_o, halted_o
   );

   modport master (
      output stall_i, branch_taken_i, branch_target_i, imem_data_i,
      input  imem_addr_o, pc_o, instr_o, instr_op_o, pc_plus4_o, valid_o, halted_o
   );
endinterface

// File: rtl/instr_fetch_ifid.sv
// Instruction-fetch stage: program counter, next-PC selection and the IF/ID register.
// Ports:
//   clk_i : clock, all state updates on the rising edge
//   rst_i : asynchronous active-low reset
//   bus   : instr_fetch_ifid_if.slave (fetch control in, imem bus, IF/ID outputs)
// After reset one BOOT edge passes with no capture. In RUN each edge either redirects
// (branch), holds (stall), captures the word at pc_o, or stops on HALT_OP. In HALTED
// only a branch restarts fetch. Every output comes straight from a register.
module instr_fetch_ifid #(
   parameter int unsigned         PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
   parameter logic [5:0]          HALT_OP  = 6'b111111
) (
   input logic                clk_i,
   input logic                rst_i,
   instr_fetch_ifid_if.slave  bus
);

   typedef enum logic [1:0] {StBoot, StRun, StHalted} state_e;

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [31:0]         instr_q, instr_d;
   logic [PC_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
   logic                valid_q, valid_d;
   logic                halted_q, halted_d;

   logic [PC_WIDTH-1:0] pc_inc;
   logic [PC_WIDTH-1:0] redirect_pc;

   // Wraps modulo 2^PC_WIDTH by construction.
   assign pc_inc      = pc_q + PC_WIDTH'(4);
   assign redirect_pc = {bus.branch_target_i[PC_WIDTH-1:2], 2'b00};

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      halted_d   = halted_q;

      unique case (state_q)
         StBoot: begin
            state_d = StRun;
         end

         StRun: begin
            if (bus.branch_taken_i) begin
               // Branch beats stall; the word being fetched is squashed.
               pc_d       = redirect_pc;
               instr_d    = '0;
               pc_plus4_d = '0;
               valid_d    = 1'b0;
            end else if (bus.stall_i) begin
               // Hold everything.
            end else if (bus.imem_data_i[31:26] == HALT_OP) begin
               // Halt word is never presented as valid; PC stays on it.
               instr_d    = '0;
               pc_plus4_d = '0;
               valid_d    = 1'b0;
               halted_d   = 1'b1;
               state_d    = StHalted;
            end else begin
               pc_d       = pc_inc;
               instr_d    = bus.imem_data_i;
               pc_plus4_d = pc_inc;
               valid_d    = 1'b1;
            end
         end

         StHalted: begin
            if (bus.branch_taken_i) begin
               pc_d       = redirect_pc;
               instr_d    = '0;
               pc_plus4_d = '0;
               valid_d    = 1'b0;
               halted_d   = 1'b0;
               state_d    = StRun;
            end
         end

         default: begin
            state_d = StBoot;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= StBoot;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         pc_plus4_q <= '0;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
      end
   end

   assign bus.imem_addr_o = pc_q;
   assign bus.pc_o        = pc_q;
   assign bus.instr_o     = instr_q;
   assign bus.instr_op_o  = instr_q[31:26];
   assign bus.pc_plus4_o  = pc_plus4_q;
   assign bus.valid_o     = valid_q;
   assign bus.halted_o    = halted_q;

endmodule

// File: tb/tb_instr_fetch_ifid.sv
// Bench for instr_fetch_ifid: directed walk through reset, stall, branch, halt and
// wrap-around, then randomized control against a fetch reference model.
module tb_instr_fetch_ifid;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_ifid_if #(.PC_WIDTH(32)) bus0 ();
   instr_fetch_ifid_if #(.PC_WIDTH(32)) bus1 ();

   instr_fetch_ifid #(
      .PC_WIDTH (32),
      .RESET_PC (32'h0000_0000),
      .HALT_OP  (6'b111111)
   ) u_dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus0)
   );

   // Second instance starts at the top of the address space to exercise PC wrap.
   instr_fetch_ifid #(
      .PC_WIDTH (32),
      .RESET_PC (32'hFFFF_FFFC),
      .HALT_OP  (6'b111111)
   ) u_dut_wrap (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus1)
   );

   // 64-word instruction memory, aliased over the address space by addr[7:2].
   logic [31:0] mem [64];
   assign bus0.imem_data_i = mem[bus0.imem_addr_o[7:2]];
   assign bus1.imem_data_i = {6'b001000, bus1.imem_addr_o[25:0]};

   int n_total = 0;
   int n_pass  = 0;
   bit check_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: what the IF/ID register and fetch PC must hold after each edge.
   logic [31:0] m_pc      = 32'h0;
   logic [31:0] m_instr   = 32'h0;
   logic [31:0] m_pp4     = 32'h0;
   logic        m_valid   = 1'b0;
   logic        m_halted  = 1'b0;
   logic        m_boot    = 1'b1;
   logic        m_pp4_known = 1'b1;

   task automatic model_reset();
      m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_boot = 1'b1; m_pp4_known = 1'b1;
   endtask

   task automatic model_redirect(input logic [31:0] tgt);
      m_pc = tgt & 32'hFFFF_FFFC;
      m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_pp4_known = 1'b1;
   endtask

   task automatic model_step();
      logic [31:0] w;
      if (m_boot) begin
         m_boot = 1'b0;
      end else if (m_halted) begin
         if (bus0.branch_taken_i) begin
            model_redirect(bus0.branch_target_i);
            m_halted = 1'b0;
         end
      end else if (bus0.branch_taken_i) begin
         model_redirect(bus0.branch_target_i);
      end else if (!bus0.stall_i) begin
         w = mem[m_pc[7:2]];
         if (w[31:26] == 6'h3F) begin
            m_halted = 1'b1; m_instr = 32'h0; m_valid = 1'b0; m_pp4_known = 1'b0;
         end else begin
            m_instr = w;
            m_pc = m_pc + 32'd4;
            m_pp4 = m_pc;
            m_valid = 1'b1;
            m_pp4_known = 1'b1;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // Per-cycle compare of the primary instance against the model.
   always @(negedge clk) begin
      if (check_en) begin
         check("cmp_pc", bus0.pc_o, m_pc);
         check("cmp_addr", bus0.imem_addr_o, m_pc);
         check("cmp_instr", bus0.instr_o, m_instr);
         check("cmp_op", bus0.instr_op_o, m_instr[31:26]);
         check("cmp_valid", bus0.valid_o, m_valid);
         check("cmp_halted", bus0.halted_o, m_halted);
         if (m_pp4_known) check("cmp_pp4", bus0.pc_plus4_o, m_pp4);
      end
   end

   task automatic drive(input logic stall, input logic br, input logic [31:0] tgt);
      bus0.stall_i = stall;
      bus0.branch_taken_i = br;
      bus0.branch_target_i = tgt;
   endtask

   task automatic random_run(input int n);
      for (int i = 0; i < n; i++) begin
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
               32'($urandom_range(0, 255)));
         @(negedge clk);
      end
   endtask

   initial begin
      bit found;
      drive(1'b0, 1'b0, 32'h0);
      bus1.stall_i = 1'b0;
      bus1.branch_taken_i = 1'b0;
      bus1.branch_target_i = 32'h0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 | 32'(i);
      mem[0]    = 32'h2008_0005;
      mem[1]    = 32'h2009_0007;
      mem[2]    = 32'h0000_0000;
      mem[8]    = 32'hFC00_0000;
      mem[16]   = 32'h2010_0040;
      check_en  = 1'b1;

      // Reset values held while rst is low.
      repeat (2) @(negedge clk);
      check("rst_pc", bus0.pc_o, 32'h0);
      check("rst_instr", bus0.instr_o, 32'h0);
      check("rst_pp4", bus0.pc_plus4_o, 32'h0);
      check("rst_valid", bus0.valid_o, 1'b0);
      check("rst_halted", bus0.halted_o, 1'b0);
      check("rst_wrap_pc", bus1.pc_o, 32'hFFFF_FFFC);
      rst_n = 1'b1;

      @(negedge clk);  // BOOT edge
      check("boot_valid", bus0.valid_o, 1'b0);
      check("boot_pc", bus0.pc_o, 32'h0);
      @(negedge clk);
      check("first_instr", bus0.instr_o, 32'h2008_0005);
      check("first_pp4", bus0.pc_plus4_o, 32'h4);
      check("first_valid", bus0.valid_o, 1'b1);
      check("wrap_pc", bus1.pc_o, 32'h0);
      check("wrap_pp4", bus1.pc_plus4_o, 32'h0);
      check("wrap_instr", bus1.instr_o, 32'h23FF_FFFC);
      check("wrap_valid", bus1.valid_o, 1'b1);
      @(negedge clk);
      check("second_instr", bus0.instr_o, 32'h2009_0007);
      check("second_pc", bus0.pc_o, 32'h8);

      drive(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_pc", bus0.pc_o, 32'h8);
         check("stall_instr", bus0.instr_o, 32'h2009_0007);
         check("stall_valid", bus0.valid_o, 1'b1);
      end
      drive(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check("resume_pc", bus0.pc_o, 32'hC);
      check("nop_valid", bus0.valid_o, 1'b1);
      check("nop_instr", bus0.instr_o, 32'h0);
      @(negedge clk);
      check("pre_branch_pc", bus0.pc_o, 32'h10);

      drive(1'b1, 1'b1, 32'h0000_0043);
      @(negedge clk);
      check("branch_pc", bus0.pc_o, 32'h40);
      check("branch_bubble", bus0.valid_o, 1'b0);
      check("branch_pp4", bus0.pc_plus4_o, 32'h0);
      drive(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check("target_instr", bus0.instr_o, 32'h2010_0040);
      check("target_valid", bus0.valid_o, 1'b1);

      drive(1'b0, 1'b1, 32'h20);
      @(negedge clk);
      check("to_halt_pc", bus0.pc_o, 32'h20);
      drive(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check("halt_flag", bus0.halted_o, 1'b1);
      for (int i = 0; i < 4; i++) begin
         bus0.stall_i = i[0];
         @(negedge clk);
         check("halt_pc", bus0.pc_o, 32'h20);
         check("halt_valid", bus0.valid_o, 1'b0);
         check("halt_hold", bus0.halted_o, 1'b1);
      end
      drive(1'b0, 1'b1, 32'h0);
      @(negedge clk);
      check("unhalt_flag", bus0.halted_o, 1'b0);
      check("unhalt_pc", bus0.pc_o, 32'h0);
      drive(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check("restart_instr", bus0.instr_o, 32'h2008_0005);
      check("restart_pc", bus0.pc_o, 32'h4);

      // Randomized program and control.
      for (int i = 0; i < 64; i++) begin
         if ($urandom_range(0, 11) == 0) mem[i] = {6'h3F, 26'($urandom)};
         else mem[i] = {($urandom_range(0, 1) == 0) ? 6'h00 : 6'h08, 26'($urandom)};
      end
      mem[0] = 32'h2008_0005;
      mem[1] = 32'h2009_0007;
      random_run(300);

      // Asynchronous reset while IF/ID holds a valid instruction.
      drive(1'b0, 1'b1, 32'h0);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (bus0.valid_o) found = 1'b1;
      end
      check("wait_valid", found, 1'b1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_pc", bus0.pc_o, 32'h0);
      check("async_instr", bus0.instr_o, 32'h0);
      check("async_pp4", bus0.pc_plus4_o, 32'h0);
      check("async_valid", bus0.valid_o, 1'b0);
      check("async_halted", bus0.halted_o, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reboot_valid", bus0.valid_o, 1'b0);
      check("reboot_pc", bus0.pc_o, 32'h0);
      @(negedge clk);
      check("reboot_instr", bus0.instr_o, 32'h2008_0005);
      check("reboot_valid2", bus0.valid_o, 1'b1);

      random_run(300);
      check_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/instr_fetch_ifid.md
# instr_fetch_ifid

Instruction-fetch stage with program counter, next-PC selection and IF/ID pipeline register, feeding the instruction word and opcode directly to the main decoder. It drives the instruction-memory address and captures the returned word. It resolves branch redirects, stalls and flushes, and stops fetching on a halt opcode.

## Interface
- PC_WIDTH, 32, width of PC and instruction-memory address
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned
- HALT_OP, 6'b111111, opcode that halts fetch

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; asynchronous, active-low
- stall_i  in  1  hold PC and IF/ID contents
- branch_taken_i  in  1  redirect fetch to branch_target_i; squash IF/ID
- branch_target_i  in  PC_WIDTH  redirect address; bits [1:0] ignored and treated as 0
- imem_addr_o  out  PC_WIDTH  instruction-memory address; equals pc_o
- imem_data_i  in  32  instruction word; combinational read of imem_addr_o
- pc_o  out  PC_WIDTH  current fetch PC
- instr_o  out  32  IF/ID instruction word
- instr_op_o  out  6  instr_o[31:26], to decoder instr_op_i
- pc_plus4_o  out  PC_WIDTH  IF/ID copy of (fetch PC + 4)
- valid_o  out  1  IF/ID holds a real instruction; 0 = bubble
- halted_o  out  1  fetch stopped on HALT_OP

## Operation
- States: BOOT, RUN, HALTED.
- BOOT: entered on reset. First rising edge after rst_i deasserts: no capture, PC unchanged, valid_o stays 0, go to RUN.
- RUN, priority per edge is branch_taken_i > stall_i > normal:
  - branch_taken_i: PC <= {branch_target_i[PC_WIDTH-1:2],2'b00}; instr_o <= 0; valid_o <= 0; pc_plus4_o <= 0. Stall ignored.
  - stall_i (no branch): PC, instr_o, pc_plus4_o and valid_o all hold.
  - normal, imem_data_i[31:26] != HALT_OP: PC <= PC+4; instr_o <= imem_data_i; pc_plus4_o <= PC+4; valid_o <= 1.
  - normal, imem_data_i[31:26] == HALT_OP: PC holds; instr_o <= 0; valid_o <= 0; halted_o <= 1; go to HALTED.
- HALTED:
  - PC frozen. IF/ID is a bubble: instr_o=0, valid_o=0. stall_i ignored.
  - branch_taken_i: redirect PC as in RUN; halted_o <= 0; go to RUN.
- Arithmetic: PC+4 is modulo 2^PC_WIDTH. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- instr_op_o is purely combinational from instr_o.
- An all-zero word (nop/sll) is a valid instruction, captured with valid_o=1.

## Timing
- Reset values, held while rst_i=0: pc_o=RESET_PC, instr_o=0, pc_plus4_o=0, valid_o=0, halted_o=0, state BOOT.
- Reset mid-operation: all outputs take reset values immediately, without waiting for a clock edge.
- Latency: the word at pc_o in cycle N appears on instr_o in cycle N+1, with valid_o=1, unless stalled or redirected.
- Redirect: target on pc_o the cycle after branch_taken_i is sampled. Exactly one bubble (valid_o=0) follows on IF/ID.
- Branch and stall in the same cycle: branch wins.
- Stall lasting K cycles: outputs are unchanged for K cycles; fetch resumes on the first edge with stall_i=0.
- Halt: halted_o rises on the edge that samples HALT_OP. The HALT_OP word never appears with valid_o=1.
- No combinational path from any input to any output except imem_data_i to nothing; imem_addr_o comes from a register.

## Test plan
- Reset release, memory words 0x20080005, 0x20090007 at addresses 0, 4 -> BOOT cycle with valid_o=0. Next edge: instr_o=0x20080005, pc_plus4_o=4, valid_o=1. Following edge: instr_o=0x20090007, pc_o=8.
- Stall held 3 cycles at pc_o=8 -> pc_o, instr_o and valid_o constant for 3 cycles. After release, pc_o=12.
- branch_taken_i with target 0x0000_0043 and stall_i=1 together at pc_o=16 -> next pc_o=0x40, valid_o=0 for one cycle, then instr_o=mem[0x40].
- Memory word 0xFC000000 at 0x20 -> halted_o=1, pc_o stays 0x20, valid_o=0 indefinitely. Then branch_taken_i to 0x0 -> halted_o=0, fetch restarts at 0.
- RESET_PC=32'hFFFF_FFFC -> after first fetch, pc_o wraps to 0x0000_0000 and pc_plus4_o=0.
- rst_i pulled low asynchronously mid-run with valid_o=1 -> outputs return to reset values before the next edge. BOOT cycle repeats on release.
